// File: rtl/ifetch_if.sv
// ifetch_if: fetch-unit bundle (redirect, instruction memory bus, decode handshake); master = fetch unit, slave = environment
interface ifetch_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  modport master (
    input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc
  );
  modport slave (
    output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/ifetch.sv
// ifetch: single-outstanding instruction fetch with 2-entry buffer; ports clk, rst, f (ifetch_if.master); IFETCH_BYPASS_EN enables rvalid-to-decode bypass
module ifetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input logic      clk,
  input logic      rst,
  ifetch_if.master f
);
  localparam logic [1:0]  FETCH = 2'd0, WAIT = 2'd1, DROP = 2'd2;
  localparam logic [31:0] ALIGN = 32'hFFFF_FFFC;
  logic [1:0]  state, cnt;
  logic [31:0] fetch_pc, req_pc;
  logic [31:0] bd [BUF_DEPTH];
  logic [31:0] bp [BUF_DEPTH];
  logic        hd, wr, hs, byp, push, pop;
  assign f.imem_req  = !rst && state == FETCH && cnt <= 2'd1 && !f.redirect_valid;
  assign f.imem_addr = fetch_pc;
  assign hs          = f.imem_req && f.imem_gnt;
`ifdef IFETCH_BYPASS_EN
  assign byp = !rst && state == WAIT && f.imem_rvalid && !f.redirect_valid && cnt == 2'd0;
`else
  assign byp = 1'b0;
`endif
  assign f.inst_valid = !rst && (cnt != 2'd0 || byp);
  assign f.inst       = byp ? f.imem_rdata : bd[hd];
  assign f.inst_pc    = byp ? req_pc : bp[hd];
  // a bypassed word taken by decode in the same cycle never enters the buffer
  assign push = state == WAIT && f.imem_rvalid && !f.redirect_valid && !(byp && f.inst_ready);
  assign pop  = cnt != 2'd0 && f.inst_ready && !f.redirect_valid;
  assign wr   = hd ^ cnt[0];
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC & ALIGN;
      cnt      <= 2'd0;
      hd       <= 1'b0;
    end else if (f.redirect_valid) begin
      fetch_pc <= f.redirect_pc & ALIGN;
      cnt      <= 2'd0;
      // an in-flight response still has to be swallowed unless it lands this cycle
      state    <= state == FETCH ? (hs ? DROP : FETCH) : (f.imem_rvalid ? FETCH : DROP);
    end else begin
      if (hs) begin
        fetch_pc <= fetch_pc + 32'd4;
        req_pc   <= fetch_pc;
        state    <= WAIT;
      end else if (state != FETCH && f.imem_rvalid) state <= FETCH;
      if (push) begin
        bd[wr] <= f.imem_rdata;
        bp[wr] <= req_pc;
      end
      if (pop) hd <= ~hd;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the fetch address loaded on reset.
REQ-002 Parameter BUF_DEPTH, fixed at 2, is the number of instruction buffer entries.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 redirect_valid  input  1  next-PC logic requests a fetch-stream change (taken branch, jal, jalr).
REQ-006 redirect_pc  input  32  new fetch address, qualified by redirect_valid.
REQ-007 imem_req  output  1  instruction memory read request.
REQ-008 imem_addr  output  32  word-aligned read address.
REQ-009 imem_gnt  input  1  memory accepts the request this cycle.
REQ-010 imem_rvalid  input  1  read data valid.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 inst_valid  output  1  buffered instruction available to decode.
REQ-013 inst_ready  input  1  decode consumes the instruction.
REQ-014 inst  output  32  instruction word at buffer head.
REQ-015 inst_pc  output  32  address of inst.

Function
REQ-016 The block SHALL hold fetch_pc and a three-state FSM: FETCH, WAIT, DROP.
REQ-017 FETCH: imem_req SHALL be 1 when buffer count <= 1 and redirect_valid = 0; imem_addr = {fetch_pc[31:2], 2'b00}.
REQ-018 While imem_req = 1 and imem_gnt = 0, imem_req and imem_addr SHALL stay stable, except when a redirect aborts the request.
REQ-019 On imem_req & imem_gnt, fetch_pc SHALL advance by 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0) and the FSM SHALL enter WAIT.
REQ-020 Only one request SHALL be outstanding; imem_req SHALL be 0 in WAIT and DROP.
REQ-021 WAIT: on imem_rvalid, {imem_rdata, request address} SHALL be pushed into the buffer and the FSM SHALL return to FETCH.
REQ-022 imem_rvalid is valid no earlier than the cycle after grant; imem_rvalid in FETCH SHALL be ignored.
REQ-023 redirect_valid SHALL have priority over all events: fetch_pc <= {redirect_pc[31:2], 2'b00}, and the buffer SHALL be flushed.
REQ-024 Redirect in WAIT without same-cycle imem_rvalid, or in FETCH with a same-cycle grant, SHALL move the FSM to DROP.
REQ-025 Redirect in WAIT with same-cycle imem_rvalid SHALL discard that data and move the FSM to FETCH.
REQ-026 DROP: the next imem_rvalid SHALL be discarded and the FSM SHALL return to FETCH; a further redirect in DROP SHALL only update fetch_pc.
REQ-027 inst_valid SHALL equal (count != 0); inst and inst_pc SHALL show the head entry.
REQ-028 Pop on inst_valid & inst_ready; same-cycle push and pop SHALL leave count unchanged.
REQ-029 inst_valid SHALL be 0 in the cycle after a redirect.
REQ-030 A push SHALL never occur when count = 2, which REQ-017 guarantees.

Reset
REQ-031 On rst = 1 at a clock edge: fetch_pc = RESET_PC, FSM = FETCH, count = 0.
REQ-032 While rst = 1, imem_req = 0 and inst_valid = 0; the first request SHALL be issued the cycle after rst deasserts.
REQ-033 Reset during WAIT or DROP SHALL abandon the outstanding request; a late imem_rvalid arriving in FETCH SHALL be ignored per REQ-022.

Configuration
REQ-034 With IFETCH_BYPASS_EN defined, imem_rvalid in WAIT with count = 0 SHALL drive inst_valid = 1, inst = imem_rdata and inst_pc = request address combinationally in that cycle; if inst_ready = 1, no push SHALL occur.
REQ-035 Without IFETCH_BYPASS_EN, inst_valid SHALL rise no earlier than one cycle after imem_rvalid.

Verification
REQ-036 Reset release, gnt tied 1, rvalid one cycle after gnt, inst_ready = 1 -> inst_pc sequence 0x0, 0x4, 0x8 with matching inst.
REQ-037 inst_ready = 0 for 10 cycles -> count saturates at 2, imem_req = 0, no data lost; releasing ready -> in-order drain.
REQ-038 imem_gnt held 0 for 5 cycles -> imem_req = 1 and imem_addr constant throughout.
REQ-039 redirect_pc = 0x100 asserted during WAIT -> late response discarded, next imem_addr = 0x100, first inst_pc = 0x100.
REQ-040 redirect_pc = 0x203 -> imem_addr = 0x200; fetch_pc = 0xFFFF_FFFC granted -> next imem_addr = 0x0.
REQ-041 IFETCH_BYPASS_EN defined, buffer empty -> inst_valid in the same cycle as imem_rvalid; undefined -> one cycle later.
